// File: rtl/pulse_stretch.sv
// Stretches single-cycle triggers into a high run of programmable length,
// followed by a guaranteed low gap; reports the falling edge and discarded triggers.
module pulse_stretch #(
   parameter int LEN_W     = 16,
   parameter int MIN_LOW   = 1,
   parameter int RETRIGGER = 0,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic [LEN_W-1:0] len,
   input  logic             drop_clr,
   output logic             dout,
   output logic             busy,
   output logic             fall,
   output logic             dropped,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      GAP
   } state_t;

   localparam logic             RT      = (RETRIGGER != 0);
   localparam logic [LEN_W-1:0] GAP_TOP = LEN_W'(MIN_LOW - 1);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             busy_q, busy_d;
   logic             fall_q, fall_d;
   logic             dropped_q, dropped_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fall_d    = 1'b0;
      dropped_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A zero-length request is silently ignored, not counted as a drop.
            if (trig && (len != '0)) begin
               state_d = HIGH;
               cnt_d   = len - 1'b1;
            end
         end
         HIGH: begin
            dropped_d = trig && !RT;
            if (trig && RT && (len != '0)) begin
               cnt_d = len - 1'b1;
            end else if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = GAP_TOP;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            dropped_d = trig;
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      dout_d = (state_d == HIGH);
      busy_d = (state_d != IDLE);

      // A clear coinciding with a drop keeps that drop.
      if (drop_clr) begin
         drop_cnt_d = dropped_d ? CNT_W'(1) : '0;
      end else if (dropped_d && !(&drop_cnt_q)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dout_q     <= 1'b0;
         busy_q     <= 1'b0;
         fall_q     <= 1'b0;
         dropped_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dout_q     <= dout_d;
         busy_q     <= busy_d;
         fall_q     <= fall_d;
         dropped_q  <= dropped_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign dout     = dout_q;
   assign busy     = busy_q;
   assign fall     = fall_q;
   assign dropped  = dropped_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: a vector table for single runs plus hand sequences
// for retrigger, long gaps with a held trigger, saturation and mid-run reset.
module tb_pulse_stretch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trig = 1'b0;
   logic [15:0] len = '0;
   logic        drop_clr = 1'b0;

   logic       d0_dout, d0_busy, d0_fall, d0_dropped;
   logic [7:0] d0_cnt;
   logic       rt_dout, rt_busy, rt_fall, rt_dropped;
   logic [7:0] rt_cnt;
   logic       m3_dout, m3_busy, m3_fall, m3_dropped;
   logic [7:0] m3_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pulse_stretch #(.LEN_W(16), .MIN_LOW(1), .RETRIGGER(0), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .trig(trig), .len(len), .drop_clr(drop_clr),
      .dout(d0_dout), .busy(d0_busy), .fall(d0_fall), .dropped(d0_dropped), .drop_cnt(d0_cnt)
   );

   pulse_stretch #(.LEN_W(16), .MIN_LOW(1), .RETRIGGER(1), .CNT_W(8)) u_rt (
      .clk(clk), .rst_n(rst_n), .trig(trig), .len(len), .drop_clr(drop_clr),
      .dout(rt_dout), .busy(rt_busy), .fall(rt_fall), .dropped(rt_dropped), .drop_cnt(rt_cnt)
   );

   pulse_stretch #(.LEN_W(4), .MIN_LOW(3), .RETRIGGER(0), .CNT_W(8)) u_ml3 (
      .clk(clk), .rst_n(rst_n), .trig(trig), .len(len[3:0]), .drop_clr(drop_clr),
      .dout(m3_dout), .busy(m3_busy), .fall(m3_fall), .dropped(m3_dropped), .drop_cnt(m3_cnt)
   );

   typedef struct {
      logic        trig;
      logic [15:0] len;
      logic        clr;
      logic        dout;
      logic        busy;
      logic        fall;
      logic        dropped;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      trig     = 1'b0;
      len      = '0;
      drop_clr = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic add(input logic t, input logic [15:0] l, input logic c,
                      input logic d, input logic b, input logic f, input logic dr,
                      input logic [7:0] n);
      vec_t v;
      v = '{t, l, c, d, b, f, dr, n};
      tbl.push_back(v);
   endtask

   // Retrigger-mode run: trigger with l0, re-trigger with lr during the at-th high cycle.
   task automatic rt_run(input logic [15:0] l0, input int at, input logic [15:0] lr,
                         input int exp_hc, input string nm);
      int hc = 0;
      int fc = 0;
      bit fired = 0;
      bit seen_low = 0;
      bit broke = 0;
      do_reset();
      trig = 1'b1;
      len  = l0;
      for (int i = 0; i < 40; i++) begin
         step();
         trig = 1'b0;
         if (rt_dout) hc++;
         if (rt_fall) fc++;
         if (!rt_dout && hc > 0) seen_low = 1;
         if (rt_dout && seen_low) broke = 1;
         if (!fired && hc == at && rt_dout) begin
            trig  = 1'b1;
            len   = lr;
            fired = 1;
         end
      end
      check({nm, ".high_cycles"}, hc, exp_hc);
      check({nm, ".contiguous"}, broke, 0);
      check({nm, ".fall_pulses"}, fc, 1);
      check({nm, ".drop_cnt"}, rt_cnt, 0);
      check({nm, ".busy_end"}, rt_busy, 0);
   endtask

   initial begin
      int hc;
      int fc;
      int bc;
      bit found;

      // Single runs on the MIN_LOW=1, no-retrigger instance.
      // trig len dclr | dout busy fall dropped drop_cnt
      add(1, 0, 0,  0, 0, 0, 0, 0);   // zero length ignored
      add(1, 4, 0,  1, 1, 0, 0, 0);   // len=4 run
      add(0, 4, 0,  1, 1, 0, 0, 0);
      add(0, 4, 0,  1, 1, 0, 0, 0);
      add(0, 4, 0,  1, 1, 0, 0, 0);
      add(0, 4, 0,  0, 1, 1, 0, 0);   // one-cycle gap with fall
      add(0, 4, 0,  0, 0, 0, 0, 0);
      add(1, 8, 0,  1, 1, 0, 0, 0);   // len=8 run, cycle 1
      add(0, 8, 0,  1, 1, 0, 0, 0);
      add(0, 8, 0,  1, 1, 0, 0, 0);
      add(1, 8, 0,  1, 1, 0, 1, 1);   // trig in cycle 3 dropped
      add(0, 2, 0,  1, 1, 0, 0, 1);   // len change mid-run has no effect
      add(0, 2, 0,  1, 1, 0, 0, 1);
      add(0, 2, 0,  1, 1, 0, 0, 1);
      add(0, 2, 0,  1, 1, 0, 0, 1);   // cycle 8
      add(0, 2, 0,  0, 1, 1, 0, 1);
      add(0, 2, 0,  0, 0, 0, 0, 1);
      add(0, 2, 1,  0, 0, 0, 0, 0);   // clear alone
      add(1, 1, 0,  1, 1, 0, 0, 0);   // len=1 run
      add(0, 1, 0,  0, 1, 1, 0, 0);
      add(1, 1, 0,  0, 0, 0, 1, 1);   // trig during gap dropped
      add(1, 1, 0,  1, 1, 0, 0, 1);
      add(0, 1, 0,  0, 1, 1, 0, 1);
      add(0, 1, 0,  0, 0, 0, 0, 1);

      do_reset();
      check("reset.dout", d0_dout, 0);
      check("reset.busy", d0_busy, 0);
      check("reset.fall", d0_fall, 0);
      check("reset.dropped", d0_dropped, 0);
      check("reset.drop_cnt", d0_cnt, 0);

      foreach (tbl[i]) begin
         trig     = tbl[i].trig;
         len      = tbl[i].len;
         drop_clr = tbl[i].clr;
         step();
         check($sformatf("v%0d.dout", i), d0_dout, tbl[i].dout);
         check($sformatf("v%0d.busy", i), d0_busy, tbl[i].busy);
         check($sformatf("v%0d.fall", i), d0_fall, tbl[i].fall);
         check($sformatf("v%0d.dropped", i), d0_dropped, tbl[i].dropped);
         check($sformatf("v%0d.drop_cnt", i), d0_cnt, tbl[i].cnt);
      end

      // Retrigger: mid-run reload, reload on the last high cycle, zero-length reload ignored.
      rt_run(16'd8, 5, 16'd8, 13, "rt_mid");
      rt_run(16'd2, 2, 16'd3, 5, "rt_last");
      rt_run(16'd3, 1, 16'd0, 3, "rt_len0");

      // MIN_LOW=3 with trig held: accept, 2 high, 3 gap, 1 idle -> 6-cycle period, 5 drops each.
      do_reset();
      trig = 1'b1;
      len  = 16'd2;
      for (int s = 1; s <= 18; s++) begin
         step();
         check($sformatf("ml3_held.dout[%0d]", s), m3_dout, ((s - 1) % 6) < 2);
         check($sformatf("ml3_held.fall[%0d]", s), m3_fall, ((s - 1) % 6) == 2);
         check($sformatf("ml3_held.busy[%0d]", s), m3_busy, ((s - 1) % 6) < 5);
      end
      check("ml3_held.drop_cnt", m3_cnt, 15);

      // Full-length run on the 4-bit counter instance.
      do_reset();
      trig = 1'b1;
      len  = 16'd15;
      hc = 0; fc = 0; bc = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         trig = 1'b0;
         if (m3_dout) hc++;
         if (m3_fall) fc++;
         if (m3_busy) bc++;
      end
      check("ml3_full.high_cycles", hc, 15);
      check("ml3_full.fall_pulses", fc, 1);
      check("ml3_full.busy_cycles", bc, 18);

      // Saturation: held trig with len=1 gives 2 drops per 3 cycles, ~306 drops here.
      do_reset();
      trig = 1'b1;
      len  = 16'd1;
      repeat (460) step();
      check("sat.drop_cnt", d0_cnt, 255);
      found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         if (d0_dout) found = 1;
         else step();
      end
      check("sat.found_high", found, 1);
      drop_clr = 1'b1;
      step();
      check("clr_with_drop.drop_cnt", d0_cnt, 1);
      check("clr_with_drop.dropped", d0_dropped, 1);
      trig = 1'b0;
      step();
      drop_clr = 1'b0;
      check("clr_alone.drop_cnt", d0_cnt, 0);

      // Reset during the second high cycle of a len=10 run.
      do_reset();
      trig = 1'b1;
      len  = 16'd10;
      step();
      trig = 1'b0;
      step();
      check("midrst.dout_before", d0_dout, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.dout_async", d0_dout, 0);
      check("midrst.busy_async", d0_busy, 0);
      step();
      rst_n = 1'b1;
      fc = 0; hc = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (d0_fall) fc++;
         if (d0_dout) hc++;
      end
      check("midrst.no_fall", fc, 0);
      check("midrst.no_high", hc, 0);
      trig = 1'b1;
      len  = 16'd1;
      step();
      trig = 1'b0;
      check("midrst.len1_high", d0_dout, 1);
      step();
      check("midrst.len1_low", d0_dout, 0);
      check("midrst.len1_fall", d0_fall, 1);
      step();
      check("midrst.len1_idle", d0_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
